// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-low polarity, digit enables and glyph table.
// Segment vectors are ordered {g,f,e,d,c,b,a}: bit 0 drives a, bit 6 drives g.
package seg7_pkg;

  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;

  typedef logic [6:0] glyph_t;

  localparam glyph_t     GLYPH_BLANK = {7{SEG_OFF}};
  localparam glyph_t     GLYPH_DASH  = 7'b0111111;
  localparam logic [3:0] AN_NONE     = {4{SEG_OFF}};

  localparam glyph_t GLYPH_TABLE [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Non-decimal codes render as a dash so a corrupted count is visible.
  function automatic glyph_t bcd_glyph(input logic [3:0] digit);
    if (digit > 4'd9) return GLYPH_DASH;
    return GLYPH_TABLE[digit];
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decode with a blanking override.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output glyph_t     seg
);

  always_comb begin
    // NOTE: seg gets a default before any condition so no path leaves it unassigned and no latch is inferred.
    seg = GLYPH_BLANK;
    if (!blank) seg = bcd_glyph(digit);
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed MM:SS display driver with frame-coherent snapshot,
// optional leading-zero blanking and a blinking colon while the stopwatch runs.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk_in,
  input  logic        RESET,
  input  logic [16:1] Q,
  input  logic        RUN,
  input  logic        LZB,
  output logic [4:1]  AN,
  output logic [7:1]  SEG,
  output logic        DP
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] presc;
  logic [1:0]       idx;
  logic [FRM_W-1:0] frame_cnt;
  logic [16:1]      shadow;
  logic             colon;
  logic             tick;
  logic             frame_end;
  logic [3:0]       digit;
  logic             lead_blank;
  glyph_t           glyph;

  assign tick      = (presc == DIV_LAST);
  assign frame_end = tick && (idx == 2'd3);

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      presc <= '0;
      idx   <= 2'd0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      presc <= tick ? '0 : presc + DIV_W'(1);
      if (tick) idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      // NOTE: the shadow is reset rather than left unknown because the first frame after reset displays it as 0000.
      shadow    <= '0;
      frame_cnt <= '0;
      colon     <= 1'b1;
    end else begin
      if (frame_end) shadow <= Q;
      if (!RUN) begin
        frame_cnt <= '0;
        colon     <= 1'b1;
      end else if (frame_end) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt <= '0;
          colon     <= ~colon;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end
    end
  end

  always_comb begin
    digit = shadow[4:1];
    case (idx)
      2'd1:    digit = shadow[8:5];
      2'd2:    digit = shadow[12:9];
      2'd3:    digit = shadow[16:13];
      default: digit = shadow[4:1];
    endcase
  end

  assign lead_blank = LZB && (idx == 2'd3) && (digit == 4'd0);

  bcd_to_seg7 u_decode (
    .digit (digit),
    .blank (lead_blank),
    .seg   (glyph)
  );

  // Outputs follow idx by one cycle; the colon sits on the minutes digit's DP.
  always_ff @(posedge clk_in) begin
    if (RESET) begin
      AN  <= AN_NONE;
      SEG <= GLYPH_BLANK;
      DP  <= SEG_OFF;
    end else begin
      AN  <= ~(4'b0001 << idx);
      SEG <= glyph;
      DP  <= ((idx == 2'd2) && colon) ? SEG_ON : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed frame sequences, a vector table
// and a randomized run compared against a cycle-counting reference model.
module tb_seg7_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * SCAN_DIV;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GB = 7'b1111111;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [16:1] q;
  logic        run;
  logic        lzb;
  logic [4:1]  an;
  logic [7:1]  seg;
  logic        dp;

  int total = 0;
  int bad   = 0;

  seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk_in (clk_in),
    .RESET  (rst),
    .Q      (q),
    .RUN    (run),
    .LZB    (lzb),
    .AN     (an),
    .SEG    (seg),
    .DP     (dp)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Reference glyphs built from the lit-segment letters of each digit.
  string seg_names [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [6:0] ref_glyph(input int d);
    logic [6:0] code;
    string      s;
    int         b;
    if (d > 9) return GD;
    code = 7'h7f;
    s = seg_names[d];
    for (int i = 0; i < s.len(); i++) begin
      b = s[i] - 97;
      code[b] = 1'b0;
    end
    return code;
  endfunction

  // Model: n counts clock edges since reset release; everything else follows from it.
  int          n           = 0;
  logic [15:0] shadow_m    = 16'h0000;
  int          run_frames  = 0;
  bit          colon_m     = 1'b1;
  bit          model_valid = 1'b0;
  logic [3:0]  exp_an      = 4'hf;
  logic [6:0]  exp_seg     = 7'h7f;
  logic        exp_dp      = 1'b1;

  always @(posedge clk_in) begin : model_step
    int slot;
    int pos;
    int d;
    bit frame_done;
    if (rst) begin
      exp_an      = 4'b1111;
      exp_seg     = 7'h7f;
      exp_dp      = 1'b1;
      n           = 0;
      shadow_m    = 16'h0000;
      run_frames  = 0;
      colon_m     = 1'b1;
      model_valid = 1'b1;
    end else begin
      slot = (n / SCAN_DIV) % 4;
      pos  = n % SCAN_DIV;
      d    = int'((shadow_m >> (4 * slot)) & 16'hf);
      exp_an       = 4'b1111;
      exp_an[slot] = 1'b0;
      exp_seg      = (lzb && slot == 3 && d == 0) ? GB : ref_glyph(d);
      exp_dp       = !(slot == 2 && colon_m);
      frame_done   = (slot == 3) && (pos == SCAN_DIV - 1);
      if (frame_done) shadow_m = q;
      if (!run) run_frames = 0;
      else if (frame_done) run_frames++;
      colon_m = ((run_frames / BLINK_FRAMES) % 2) == 0;
      n++;
    end
  end

  always @(negedge clk_in) begin
    if (model_valid) begin
      check("model_an", 16'(an), 16'(exp_an));
      check("model_seg", 16'(seg), 16'(exp_seg));
      check("model_dp", 16'(dp), 16'(exp_dp));
    end
  end

  task automatic wait_mod(input int target);
    int guard = 0;
    do begin
      @(negedge clk_in);
      guard++;
    end while ((n % FRAME) != target && guard < 3 * FRAME);
    if ((n % FRAME) != target) begin
      total++;
      bad++;
      $display("FAIL sync_wait: slot position %0d, want %0d", n % FRAME, target);
    end
  endtask

  typedef struct packed {
    logic [15:0]     q;
    logic            lzb;
    logic [3:0][6:0] glyph;  // [3] = tens of minutes ... [0] = seconds
  } vec_t;

  vec_t       vecs [8];
  logic [3:0] an_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] g1020  [4] = '{G0, G2, G0, G1};
  logic [6:0] g4930  [4] = '{G0, G3, G9, G4};

  initial begin
    vecs[0] = {16'h1020, 1'b0, G1, G0, G2, G0};
    vecs[1] = {16'h059A, 1'b1, GB, G5, G9, GD};
    vecs[2] = {16'h059A, 1'b0, G0, G5, G9, GD};
    vecs[3] = {16'h4930, 1'b0, G4, G9, G3, G0};
    vecs[4] = {16'h0000, 1'b1, GB, G0, G0, G0};
    vecs[5] = {16'hFBC7, 1'b1, GD, GD, GD, G7};
    vecs[6] = {16'h0678, 1'b0, G0, G6, G7, G8};
    vecs[7] = {16'h0001, 1'b1, GB, G0, G0, G1};

    rst = 1'b1;
    q   = 16'h0000;
    run = 1'b0;
    lzb = 1'b0;
    repeat (2) @(negedge clk_in);
    check("reset_an", 16'(an), 16'h000f);
    check("reset_seg", 16'(seg), 16'h007f);
    check("reset_dp", 16'(dp), 16'h0001);

    // Scan order, first-frame zeros, frame snapshot and the blink cadence.
    q   = 16'h1020;
    run = 1'b1;
    rst = 1'b0;
    for (int c = 0; c < 6 * FRAME; c++) begin
      int s;
      int f;
      @(negedge clk_in);
      s = (c / SCAN_DIV) % 4;
      f = c / FRAME;
      check("scan_an", 16'(an), 16'(an_pat[s]));
      check("scan_seg", 16'(seg), 16'((f == 0) ? G0 : g1020[s]));
      check("blink_dp", 16'(dp), 16'(((s == 2) && ((f / 2) % 2 == 0)) ? 1'b0 : 1'b1));
    end

    // Q changes during the idx=1 slot; the frame in progress keeps its snapshot.
    for (int c = 0; c < 2 * FRAME; c++) begin
      int s;
      @(negedge clk_in);
      s = (c / SCAN_DIV) % 4;
      check("midframe_seg", 16'(seg), 16'((c < FRAME) ? g1020[s] : g4930[s]));
      if (c == SCAN_DIV) q = 16'h4930;
    end

    for (int v = 0; v < 8; v++) begin
      q   = vecs[v].q;
      lzb = vecs[v].lzb;
      wait_mod(0);
      for (int c = 0; c < FRAME; c++) begin
        int s;
        @(negedge clk_in);
        s = c / SCAN_DIV;
        check("vec_an", 16'(an), 16'(an_pat[s]));
        check("vec_seg", 16'(seg), 16'(vecs[v].glyph[s]));
      end
    end

    // Colon held on while stopped.
    run = 1'b0;
    lzb = 1'b0;
    wait_mod(0);
    for (int c = 0; c < 3 * FRAME; c++) begin
      int s;
      @(negedge clk_in);
      s = (c / SCAN_DIV) % 4;
      check("stopped_dp", 16'(dp), 16'((s == 2) ? 1'b0 : 1'b1));
    end

    // One-cycle reset in the idx=2 slot aborts the frame and restarts from a zero shadow.
    q   = 16'h1234;
    run = 1'b1;
    wait_mod(0);
    wait_mod(2 * SCAN_DIV + 1);
    rst = 1'b1;
    @(negedge clk_in);
    check("midreset_an", 16'(an), 16'h000f);
    check("midreset_seg", 16'(seg), 16'h007f);
    check("midreset_dp", 16'(dp), 16'h0001);
    rst = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      int s;
      @(negedge clk_in);
      s = c / SCAN_DIV;
      check("restart_an", 16'(an), 16'(an_pat[s]));
      check("restart_seg", 16'(seg), 16'(G0));
      check("restart_dp", 16'(dp), 16'((s == 2) ? 1'b0 : 1'b1));
    end

    // Random inputs and occasional reset pulses, checked by the model every cycle.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_in);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) q = 16'($urandom);
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      if ($urandom_range(0, 47) == 0) run = ~run;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

endmodule
